code_calc_seq: RTL and testbench

Sequential, parametrised code calculator. It accepts N unsigned W-bit values serially and insertion-sorts them as they arrive. It then normalises the sorted vector and evaluates one of two opt-selected equations with a single shared multiplier. It is the next generation of the combinational 5×4-bit code calculator: generalised N and W, a registered load/compute pipeline, a busy indication and fixed-latency output.

---
 rtl/code_calc_pkg.sv | 11 +
 rtl/code_calc_sorter.sv | 28 ++
 rtl/code_calc_seq.sv | 134 +++++++++++++
 tb/tb_code_calc_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/code_calc_pkg.sv
// code_calc_pkg: shared FSM states, opt bit positions and internal width helper
package code_calc_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, NORM, AVG, MUL1, MUL2, OUT} state_t;
  localparam int OPT_NORM = 0;
  localparam int OPT_DESC = 1;
  localparam int OPT_EQ   = 2;
  // Headroom for sums of products of (W+1)-bit signed values and an N-term sum.
  function automatic int calc_w(input int w, input int n);
    return 2 * w + $clog2(n) + 4;
  endfunction
endpackage

// File: rtl/code_calc_sorter.sv
// code_calc_sorter: N-entry ascending insertion sorter, one insert per cycle
module code_calc_sorter
  import code_calc_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                ins_valid,
  input  logic [W-1:0]        ins_data,
  output logic [N-1:0][W-1:0] sorted
);
  logic [N-1:0][W-1:0] r_s, w_nxt;
  for (genvar i = 0; i < N; i++) begin : g_ins
    if (i < N - 1) begin : g_mid
      assign w_nxt[i] = r_s[i+1] <= ins_data ? r_s[i+1] : r_s[i] <= ins_data ? ins_data : r_s[i];
    end else begin : g_top
      assign w_nxt[i] = r_s[i] <= ins_data ? ins_data : r_s[i];
    end
  end
  // Insert by shifting smaller entries down and dropping entry 0; the cleared zeros fall out after N inserts.
  always_ff @(posedge clk)
    if (rst || clr) r_s <= '0;
    else if (ins_valid) r_s <= w_nxt;
  assign sorted = r_s;
endmodule

// File: rtl/code_calc_seq.sv
// code_calc_seq: serial sort-and-evaluate code calculator; define CODE_CALC_SAT_EN to saturate the result instead of wrapping
module code_calc_seq
  import code_calc_pkg::*;
#(
  parameter int N  = 5,
  parameter int W  = 4,
  parameter int OW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic [2:0]    opt,
  output logic          busy,
  output logic          out_valid,
  output logic [OW-1:0] out_data
);
  localparam int XW = calc_w(W, N) > OW ? calc_w(W, N) : OW + 1;
  localparam int CW = $clog2(N);
  typedef logic signed [XW-1:0] x_t;
  typedef logic signed [W:0] n_t;
  localparam x_t NX    = x_t'(N);
  localparam x_t THREE = x_t'(3);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_opt;
  n_t                  r_n [N];
  x_t                  r_sum, r_avg, r_p1;
  logic                r_busy, r_ov;
  logic [OW-1:0]       r_od;
  logic                w_accept;
  logic [N-1:0][W-1:0] w_s;
  logic [W:0]          w_a;
  n_t                  w_n [N];
  x_t                  w_sum, w_ma, w_mb, w_p, w_t, w_res;
  logic [OW-1:0]       w_q;

  assign w_accept = in_valid && (r_state == IDLE || r_state == LOAD);

  code_calc_sorter #(.N(N), .W(W)) u_sorter (
    .clk      (clk),
    .rst      (rst),
    .clr      (r_state == OUT),
    .ins_valid(w_accept),
    .ins_data (in_data),
    .sorted   (w_s)
  );

  // Normalise the (optionally reversed) sorted vector and total it for the NORM registers.
  always_comb begin
    w_a = r_opt[OPT_NORM] ? ({1'b0, w_s[0]} + {1'b0, w_s[N-1]}) >> 1 : '0;
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_n[i] = $signed({1'b0, r_opt[OPT_DESC] ? w_s[N-1-i] : w_s[i]}) - $signed(w_a);
      w_sum = w_sum + x_t'(w_n[i]);
    end
  end

  // One multiplier: p1 operands in MUL1, n[N-2]*avg in MUL2; the final equation is formed in MUL2.
  always_comb begin
    w_ma = r_state == MUL2 ? x_t'(r_n[N-2]) : r_opt[OPT_EQ] ? x_t'(r_n[0]) : x_t'(r_n[1]);
    w_mb = r_state == MUL2 ? r_avg : r_opt[OPT_EQ] ? x_t'(r_n[N-1]) : x_t'(r_n[2]);
    w_p = w_ma * w_mb;
    w_t = THREE * x_t'(r_n[N-2]) - r_p1;
    w_res = r_opt[OPT_EQ] ? (w_t < 0 ? -w_t : w_t) : (x_t'(r_n[0]) + w_p + r_p1) / THREE;
  end

`ifdef CODE_CALC_SAT_EN
  localparam x_t MAXV = x_t'(2 ** (OW - 1) - 1);
  localparam x_t MINV = -MAXV - x_t'(1);
  assign w_q = w_res > MAXV ? OW'(MAXV) : w_res < MINV ? OW'(MINV) : OW'(w_res);
`else
  assign w_q = OW'(w_res);
`endif

  // Job sequencer: load beats, then one pipeline step per state with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_opt   <= '0;
      r_n     <= '{default: '0};
      r_sum   <= '0;
      r_avg   <= '0;
      r_p1    <= '0;
      r_busy  <= 1'b0;
      r_ov    <= 1'b0;
      r_od    <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_opt   <= opt;
          r_cnt   <= CW'(1);
          r_busy  <= 1'b1;
          r_state <= LOAD;
        end
        LOAD: if (in_valid) begin
          r_cnt   <= r_cnt == CW'(N - 1) ? '0 : r_cnt + 1'b1;
          r_state <= r_cnt == CW'(N - 1) ? NORM : LOAD;
        end
        NORM: begin
          r_n     <= w_n;
          r_sum   <= w_sum;
          r_state <= AVG;
        end
        AVG: begin
          r_avg   <= r_sum / NX;
          r_state <= MUL1;
        end
        MUL1: begin
          r_p1    <= w_p;
          r_state <= MUL2;
        end
        MUL2: begin
          r_ov    <= 1'b1;
          r_od    <= w_q;
          r_state <= OUT;
        end
        OUT: begin
          r_ov    <= 1'b0;
          r_od    <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_ov;
  assign out_data  = r_od;
endmodule

// File: tb/tb_code_calc_seq.sv
// tb_code_calc_seq: randomized self-checking bench against a plain-arithmetic reference model
module tb_code_calc_seq;
  localparam int N = 5, W = 4, OW = 10;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [W-1:0] in_data = '0;
  logic [2:0] opt = '0;
  logic busy, out_valid;
  logic [OW-1:0] out_data;
  logic s_in_valid = 0;
  logic [7:0] s_in_data = '0;
  logic [2:0] s_opt = '0;
  logic s_busy, s_out_valid;
  logic [7:0] s_out_data;
  int n_pass = 0, n_chk = 0;

  always #5 clk = ~clk;

  code_calc_seq #(.N(N), .W(W), .OW(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .opt(opt),
    .busy(busy), .out_valid(out_valid), .out_data(out_data)
  );

  code_calc_seq #(.N(5), .W(8), .OW(8)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data), .opt(s_opt),
    .busy(s_busy), .out_valid(s_out_valid), .out_data(s_out_data)
  );

  function automatic int ref_calc(input int v[16], input int nn, input logic [2:0] op);
    int s[16], n[16];
    int a, sum, avg, p1, p2, t;
    for (int i = 0; i < nn; i++) s[i] = v[i];
    for (int i = 0; i < nn; i++)
      for (int j = 0; j < nn - 1 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    a = op[0] ? (s[0] + s[nn-1]) / 2 : 0;
    sum = 0;
    for (int i = 0; i < nn; i++) begin
      n[i] = (op[1] ? s[nn-1-i] : s[i]) - a;
      sum += n[i];
    end
    avg = sum / nn;
    p1 = op[2] ? n[0] * n[nn-1] : n[1] * n[2];
    p2 = n[nn-2] * avg;
    t = 3 * n[nn-2] - p1;
    return op[2] ? (t < 0 ? -t : t) : (n[0] + p2 + p1) / 3;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sends one job to dut; returns latency after the last beat and the outputs around the strobe.
  task automatic send_job(input int v[16], input logic [2:0] op, input int g[16], input bit junk,
                          output int lat, output logic [OW-1:0] d, output logic b5,
                          output logic b6, output logic ov6, output logic [OW-1:0] d6);
    lat = -1; d = '0; b5 = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < g[i]; j++) begin
        in_valid = 0; in_data = W'($urandom); opt = 3'($urandom);
        tick;
      end
      in_valid = 1;
      in_data = W'(v[i]);
      opt = i == 0 ? op : 3'($urandom);
      tick;
    end
    in_valid = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      if (out_valid) begin lat = k; d = out_data; b5 = busy; end
      in_valid = junk && k <= 5;
      in_data = W'($urandom);
      opt = 3'($urandom);
      tick;
    end
    b6 = busy; ov6 = out_valid; d6 = out_data;
    in_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 1; in_data = '1; opt = 3'b111;
    repeat (3) tick;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    n_chk++; if (s_busy !== 1'b0 || s_out_valid !== 1'b0) $display("FAIL reset_sat got busy=%b ov=%b want 0 0", s_busy, s_out_valid); else n_pass++;
    rst = 0; in_valid = 0;
    tick;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_beat_dropped busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_basic;
    int v[16], g[16], lat;
    logic [OW-1:0] d, d6, e;
    logic b5, b6, ov6;
    logic [2:0] ops[4];
    ops = '{3'b000, 3'b100, 3'b011, 3'b001};
    v = '{0: 3, 1: 7, 2: 1, 3: 9, 4: 5, default: 0};
    g = '{default: 0};
    foreach (ops[i]) begin
      e = OW'(ref_calc(v, N, ops[i]));
      send_job(v, ops[i], g, 0, lat, d, b5, b6, ov6, d6);
      n_chk++; if (lat !== 5) $display("FAIL basic_latency op=%b got %0d want 5", ops[i], lat); else n_pass++;
      n_chk++; if (d !== e) $display("FAIL basic_data op=%b got %h want %h", ops[i], d, e); else n_pass++;
      n_chk++; if (b5 !== 1'b1) $display("FAIL basic_busy_out op=%b got %b want 1", ops[i], b5); else n_pass++;
      n_chk++; if (b6 !== 1'b0 || ov6 !== 1'b0 || d6 !== '0) $display("FAIL basic_after op=%b got busy=%b ov=%b d=%h want 0 0 0", ops[i], b6, ov6, d6); else n_pass++;
    end
  endtask

  task automatic test_gapped;
    int v[16], g[16], lat;
    logic [OW-1:0] d, d6, e;
    logic b5, b6, ov6;
    v = '{0: 3, 1: 7, 2: 1, 3: 9, 4: 5, default: 0};
    g = '{0: 0, 1: 1, 2: 0, 3: 2, 4: 0, default: 0};
    e = OW'(ref_calc(v, N, 3'b100));
    send_job(v, 3'b100, g, 1, lat, d, b5, b6, ov6, d6);
    n_chk++; if (lat !== 5) $display("FAIL gapped_latency got %0d want 5", lat); else n_pass++;
    n_chk++; if (d !== e) $display("FAIL gapped_data got %h want %h", d, e); else n_pass++;
    n_chk++; if (b6 !== 1'b0 || ov6 !== 1'b0) $display("FAIL gapped_after got busy=%b ov=%b want 0 0", b6, ov6); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int v[16], g[16], lat;
    logic [OW-1:0] d, d6, e;
    logic b5, b6, ov6;
    g = '{default: 0};
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < N; i++) v[i] = $urandom_range(0, 15);
      e = OW'(ref_calc(v, N, 3'(j)));
      send_job(v, 3'(j), g, 1, lat, d, b5, b6, ov6, d6);
      n_chk++; if (lat !== 5) $display("FAIL b2b_latency job=%0d got %0d want 5", j, lat); else n_pass++;
      n_chk++; if (d !== e) $display("FAIL b2b_data job=%0d got %h want %h", j, d, e); else n_pass++;
    end
  endtask

  task automatic test_abort;
    int v[16], g[16], lat;
    logic [OW-1:0] d, d6, e;
    logic b5, b6, ov6, seen;
    v = '{0: 3, 1: 7, 2: 1, 3: 9, 4: 5, default: 0};
    g = '{default: 0};
    for (int i = 0; i < N; i++) begin
      in_valid = 1; in_data = W'(v[i]); opt = 3'b100;
      tick;
    end
    in_valid = 0;
    tick;
    tick;
    rst = 1;
    tick;
    rst = 0;
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) $display("FAIL abort_outputs got busy=%b ov=%b d=%h want 0 0 0", busy, out_valid, out_data); else n_pass++;
    seen = 0;
    repeat (8) begin
      seen |= out_valid;
      tick;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL abort_no_strobe got %b want 0", seen); else n_pass++;
    e = OW'(ref_calc(v, N, 3'b000));
    send_job(v, 3'b000, g, 0, lat, d, b5, b6, ov6, d6);
    n_chk++; if (lat !== 5) $display("FAIL abort_next_latency got %0d want 5", lat); else n_pass++;
    n_chk++; if (d !== e) $display("FAIL abort_next_data got %h want %h", d, e); else n_pass++;
  endtask

  task automatic test_random;
    int v[16], g[16], lat;
    logic [OW-1:0] d, d6, e;
    logic [2:0] op;
    logic b5, b6, ov6;
    bit junk;
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = $urandom_range(0, 15);
        g[i] = $urandom_range(0, 2);
      end
      op = 3'($urandom);
      junk = 1'($urandom);
      e = OW'(ref_calc(v, N, op));
      send_job(v, op, g, junk, lat, d, b5, b6, ov6, d6);
      n_chk++; if (lat !== 5) $display("FAIL rand_latency job=%0d got %0d want 5", j, lat); else n_pass++;
      n_chk++; if (d !== e) $display("FAIL rand_data job=%0d op=%b got %h want %h", j, op, d, e); else n_pass++;
      n_chk++; if (b5 !== 1'b1 || b6 !== 1'b0 || ov6 !== 1'b0 || d6 !== '0) $display("FAIL rand_busy job=%0d got b5=%b b6=%b ov6=%b d6=%h want 1 0 0 0", j, b5, b6, ov6, d6); else n_pass++;
    end
  endtask

  task automatic test_sat;
    int v[16], x, lat;
    logic [7:0] d, e;
    v = '{0: 255, 1: 255, 2: 255, 3: 255, 4: 0, default: 0};
    x = ref_calc(v, 5, 3'b000);
`ifdef CODE_CALC_SAT_EN
    e = x > 127 ? 8'h7F : x < -128 ? 8'h80 : 8'(x);
`else
    e = 8'(x);
`endif
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1; s_in_data = 8'(v[i]); s_opt = 3'b000;
      tick;
    end
    s_in_valid = 0;
    lat = -1; d = '0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      if (s_out_valid) begin lat = k; d = s_out_data; end
      tick;
    end
    n_chk++; if (lat !== 5) $display("FAIL sat_latency got %0d want 5", lat); else n_pass++;
    n_chk++; if (d !== e) $display("FAIL sat_data got %h want %h", d, e); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gapped;
    test_back_to_back;
    test_abort;
    test_random;
    test_sat;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
